// File: rtl/motor_pkg.sv
// Shared motor-drive definitions: sequencer state encoding, default duty width
// and saturating arithmetic helpers also used by the PWM generator.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        BRAKE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int DUTY_W_DEFAULT = 8;

    // min(a + b, lim); the extra carry bit keeps the sum from wrapping
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, lim}) ? lim : sum[31:0];
    endfunction

    // max(a - b, lim) without underflow
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] floor_plus_step;
        floor_plus_step = {1'b0, lim} + {1'b0, b};
        return ({1'b0, a} >= floor_plus_step) ? (a - b) : lim;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler: counts 0..RAMP_DIV-1 and flags the last count as the
// ramp tick, so one tick is produced every RAMP_DIV clocks.
module ramp_tick_gen #(
    parameter int RAMP_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/motor_dir_sequencer.sv
// Owns the PWM duty word and DIR line: slew-limited duty changes, and direction
// reversals that ramp to zero, hold a dead time, flip DIR, then ramp back up.
module motor_dir_sequencer
    import motor_pkg::*;
#(
    parameter int DUTY_W      = DUTY_W_DEFAULT,
    parameter int RAMP_STEP   = 4,
    parameter int RAMP_DIV    = 1000,
    parameter int DEAD_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_dir,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              busy,
    output logic              done
);

    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_CYCLES - 1);
    localparam logic [31:0] STEP32 = 32'(RAMP_STEP);

    state_t            state_reg, state_next;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    logic [DUTY_W-1:0] target_reg, target_next;
    logic              dir_reg, dir_next;
    logic              pend_dir_reg, pend_dir_next;
    logic [DCW-1:0]    dead_cnt_reg, dead_cnt_next;
    logic              done_reg, done_next;

    logic              tick;
    logic              accept;
    logic [DUTY_W-1:0] ramp_target;
    logic [DUTY_W-1:0] ramp_duty;
    logic [DUTY_W-1:0] brake_duty;

    ramp_tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign cmd_ready = ((state_reg == IDLE) || (state_reg == RAMP)) && !estop;
    assign busy      = (state_reg != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // A command accepted mid-ramp steers this very cycle's step
    assign ramp_target = accept ? cmd_duty : target_reg;
    assign ramp_duty   = (duty_reg < ramp_target)
                       ? DUTY_W'(sat_add(32'(duty_reg), STEP32, 32'(ramp_target)))
                       : DUTY_W'(sat_sub(32'(duty_reg), STEP32, 32'(ramp_target)));
    assign brake_duty  = DUTY_W'(sat_sub(32'(duty_reg), STEP32, 32'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            duty_reg     <= '0;
            target_reg   <= '0;
            dir_reg      <= 1'b0;
            pend_dir_reg <= 1'b0;
            dead_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            duty_reg     <= duty_next;
            target_reg   <= target_next;
            dir_reg      <= dir_next;
            pend_dir_reg <= pend_dir_next;
            dead_cnt_reg <= dead_cnt_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        duty_next     = duty_reg;
        target_next   = target_reg;
        dir_next      = dir_reg;
        pend_dir_next = pend_dir_reg;
        dead_cnt_next = dead_cnt_reg;
        done_next     = 1'b0;

        if (estop) begin
            state_next  = IDLE;
            duty_next   = '0;
            target_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        target_next = cmd_duty;
                        if (cmd_dir != dir_reg) begin
                            pend_dir_next = cmd_dir;
                            state_next    = BRAKE;
                        end else if (cmd_duty == duty_reg) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (accept) begin
                        target_next = cmd_duty;
                    end
                    if (accept && (cmd_dir != dir_reg)) begin
                        pend_dir_next = cmd_dir;
                        state_next    = BRAKE;
                    end else if (tick) begin
                        duty_next = ramp_duty;
                        if (ramp_duty == ramp_target) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                BRAKE: begin
                    if (duty_reg == '0) begin
                        dead_cnt_next = DEAD_LOAD;
                        state_next    = DEAD;
                    end else if (tick) begin
                        duty_next = brake_duty;
                        if (brake_duty == '0) begin
                            dead_cnt_next = DEAD_LOAD;
                            state_next    = DEAD;
                        end
                    end
                end
                DEAD: begin
                    if (dead_cnt_reg == '0) begin
                        dir_next = pend_dir_reg;
                        if (target_reg == '0) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = RAMP;
                        end
                    end else begin
                        dead_cnt_next = dead_cnt_reg - DCW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign duty = duty_reg;
    assign dir  = dir_reg;
    assign done = done_reg;

endmodule

// File: doc/motor_dir_sequencer.md
# motor_dir_sequencer

Sequences the motor drive datapath: it owns the PWM duty word and the DIR line and moves both safely in response to software commands. Duty changes are slew-limited. A direction change always ramps the duty to zero, holds a dead time, flips DIR, then ramps back up. The block sits between the GPIO command registers and the PWM generator/motor header, replacing direct software writes of the duty and direction.

## Interface
- DUTY_W, 8: width of the duty word.
- RAMP_STEP, 4: duty change applied per ramp tick.
- RAMP_DIV, 1000: clocks per ramp tick; must be ≥1.
- DEAD_CYCLES, 100000: clocks of zero duty before DIR flips; must be ≥1.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_duty  in  DUTY_W  target duty.
- cmd_dir  in  1  target direction.
- estop  in  1  synchronous emergency stop, level.
- duty  out  DUTY_W  registered duty to the PWM generator.
- dir  out  1  registered DIR to the motor header.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when duty reaches target in the commanded direction.

## Operation
- States: IDLE, RAMP, BRAKE, DEAD.
- Handshake: a command is accepted on a clk edge where cmd_valid & cmd_ready. cmd_ready = (state==IDLE | state==RAMP) & ~estop.
- Accept, cmd_dir==dir: target←cmd_duty. Next state is RAMP, or stays IDLE with a done pulse if cmd_duty==duty.
- Accept, cmd_dir≠dir: target←cmd_duty, pend_dir←cmd_dir, next state BRAKE.
- Accept during RAMP retargets the ramp immediately. A direction mismatch sends RAMP to BRAKE.
- Ramp tick: a prescaler counts 0..RAMP_DIV-1 and free-runs from reset. The tick occurs when the count is RAMP_DIV-1.
- RAMP on tick:
  - If duty<target: duty←min(duty+RAMP_STEP, target).
  - If duty>target: duty←max(duty−RAMP_STEP, target).
  - Arithmetic is done at DUTY_W+1 bits, with no wrap.
  - When the updated duty equals target: go to IDLE and pulse done.
- BRAKE on tick: duty←max(duty−RAMP_STEP, 0). When duty becomes 0: load dead_cnt←DEAD_CYCLES−1 and go to DEAD. If duty is already 0 on entry, go to DEAD the next cycle.
- DEAD: dead_cnt decrements every clk. When dead_cnt==0: dir←pend_dir, then go to RAMP, or to IDLE with done if target==0.
- estop has priority over everything. While asserted: duty←0, target←0, state←IDLE, dir held, no done pulse, cmd_ready=0.

## Timing
- Reset values:
  - Outputs: duty=0, dir=0, busy=0, done=0, cmd_ready=1.
  - Internal: state=IDLE, target=0, pend_dir=0, prescaler=0, dead_cnt=0.
- duty, dir and done are registered and change on the clk edge after the deciding condition.
- busy and cmd_ready are combinational from state and estop.
- DIR never changes while duty≠0.
- DIR changes exactly DEAD_CYCLES clocks after the edge on which duty became 0.
- Ramp slope is at most RAMP_STEP per RAMP_DIV clocks.
- The first tick after accept occurs at the next prescaler rollover, so its latency is 1..RAMP_DIV clocks.
- Reset mid-operation drops straight to the reset values, asynchronously.

## Structure
- Shared package motor_pkg holds:
  - the state enum (IDLE/RAMP/BRAKE/DEAD);
  - the DUTY_W default;
  - saturating add/sub functions, reused by the PWM generator.
- Sub-module ramp_tick_gen holds the prescaler. It is parameterised by RAMP_DIV and outputs a one-cycle tick.
- The rest is one FSM with its datapath registers.

## Test plan
- Use RAMP_DIV=4, RAMP_STEP=4, DEAD_CYCLES=10 in all scenarios.
- Reset, then command (duty 20, dir 0) → duty steps 4,8,…,20 one step per tick; done pulses once with duty=20; busy falls in the same cycle.
- At duty 20, command (10, 0) → duty 16, 12, 10 (saturated to target), then done.
- At duty 20 dir 0, command (12, 1):
  - duty ramps 16…0;
  - dir stays 0 for 10 clocks after duty=0, then goes to 1;
  - duty ramps 4, 8, 12, then done;
  - cmd_ready is low throughout BRAKE and DEAD.
- During RAMP toward 200, retarget (50, 0) while duty=60 → duty descends to 50; exactly one done pulse.
- Assert estop mid-BRAKE → next edge duty=0, state IDLE, dir unchanged, no done. After release, command (0, 1) → BRAKE, then DEAD for 10 clocks, dir=1, done.
- Assert reset mid-DEAD → duty=0, dir=0 and busy=0 immediately. Then command (255, 0) → duty saturates at 255 with no wrap.
